pipeline_ctrl: RTL and testbench

Pipeline register controller for the 5-stage core. It consumes the hazard unit's `flush` and the decode/execute operand tags. It drives stall and flush enables for the IF/ID, ID/EX and EX/MEM pipeline registers, covering three cases: taken branches, load-use bubbles, and the multi-cycle mul/div stall. It also keeps two saturating performance counters.

---
 rtl/pipeline_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Pipeline register controller for the 5-stage core. It turns taken-branch
//   flushes, load-use hazards and multi-cycle mul/div operations into
//   stall/flush enables for the PC, IF/ID, ID/EX and EX/MEM registers. It also
//   keeps two saturating performance counters.
//
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   flush           : taken branch/jump resolved in EX
//   mem_read_e      : EX instruction is a load
//   rd_e            : EX destination register
//   rs1_d, rs2_d    : ID source registers
//   muldiv_start_e  : multi-cycle mul/div valid in EX
//   muldiv_done     : mul/div result valid this cycle
//   stall_f/d/e     : hold PC, IF/ID, ID/EX
//   flush_d/e/m     : clear IF/ID, ID/EX, EX/MEM
//   md_abort        : one-cycle cancel pulse to the mul/div unit
//   md_timeout      : sticky timeout flag, cleared only by rst
//   stall_count     : saturating count of cycles with stall_f=1
//   flush_count     : saturating count of cycles with flush_d=1
module pipeline_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             mem_read_e,
    input  logic [4:0]       rd_e,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             muldiv_start_e,
    input  logic             muldiv_done,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             md_abort,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(MD_TIMEOUT + 1);

    typedef enum logic {RUN, MD_WAIT} state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            lu;
    logic            abort_c;
    logic            timeout_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign lu = mem_read_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        flush_m      = 1'b0;
        abort_c      = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            RUN: begin
                if (flush) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (muldiv_start_e && !muldiv_done) begin
                    // Freeze the front end and feed a bubble into MEM while the
                    // mul/div op sits in EX.
                    stall_f      = 1'b1;
                    stall_d      = 1'b1;
                    stall_e      = 1'b1;
                    flush_m      = 1'b1;
                    state_nxt    = MD_WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end else if (muldiv_start_e) begin
                    // Single-cycle result: nothing to do.
                end else if (lu) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            MD_WAIT: begin
                if (muldiv_done) begin
                    state_nxt = RUN;
                end else if (flush) begin
                    abort_c   = 1'b1;
                    flush_d   = 1'b1;
                    flush_e   = 1'b1;
                    state_nxt = RUN;
                end else if (wait_cnt == WC_W'(MD_TIMEOUT)) begin
                    // Give up on the op: cancel the unit and discard it from EX.
                    abort_c     = 1'b1;
                    flush_e     = 1'b1;
                    timeout_hit = 1'b1;
                    state_nxt   = RUN;
                end else begin
                    stall_f      = 1'b1;
                    stall_d      = 1'b1;
                    stall_e      = 1'b1;
                    flush_m      = 1'b1;
                    wait_cnt_nxt = wait_cnt + WC_W'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // The mul/div unit is reset alongside us, so a reset never needs a cancel.
    assign md_abort = abort_c && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            md_timeout  <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_hit) md_timeout <= 1'b1;
            if (stall_f) stall_count <= sat_inc(stall_count);
            if (flush_d) flush_count <= sat_inc(flush_count);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Directed bench for pipeline_ctrl with a behavioural reference model that is
//   checked against the DUT on every negative clock edge, plus hand-computed
//   literal expectations along the directed sequence.
module tb_pipeline_ctrl;

    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 4;
    localparam int SAT        = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             mem_read_e;
    logic [4:0]       rd_e;
    logic [4:0]       rs1_d;
    logic [4:0]       rs2_d;
    logic             muldiv_start_e;
    logic             muldiv_done;
    logic             stall_f, stall_d, stall_e;
    logic             flush_d, flush_e, flush_m;
    logic             md_abort, md_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_read_e(mem_read_e),
        .rd_e(rd_e), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .muldiv_start_e(muldiv_start_e), .muldiv_done(muldiv_done),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .md_abort(md_abort), .md_timeout(md_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model tracks whether a mul/div op is outstanding and how many stall
    // cycles it has consumed; counters are plain integers clamped at SAT.
    bit m_md, n_md;
    int m_cyc, n_cyc;
    bit m_to, n_to;
    int m_sc, n_sc, m_fc, n_fc;

    always @(negedge clk) begin
        bit lu, sf, sd, se, fd, fe, fm, ab;
        lu = mem_read_e && (rd_e != 0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
        {sf, sd, se, fd, fe, fm, ab} = '0;
        n_md = m_md; n_cyc = m_cyc; n_to = m_to;
        if (!m_md) begin
            if (flush) begin
                fd = 1; fe = 1;
            end else if (muldiv_start_e && !muldiv_done) begin
                sf = 1; sd = 1; se = 1; fm = 1; n_md = 1; n_cyc = 1;
            end else if (!muldiv_start_e && lu) begin
                sf = 1; sd = 1; fe = 1;
            end
        end else begin
            if (muldiv_done) begin
                n_md = 0;
            end else if (flush) begin
                ab = 1; fd = 1; fe = 1; n_md = 0;
            end else if (m_cyc >= MD_TIMEOUT) begin
                ab = 1; fe = 1; n_to = 1; n_md = 0;
            end else begin
                sf = 1; sd = 1; se = 1; fm = 1; n_cyc = m_cyc + 1;
            end
        end
        if (rst) ab = 0;
        n_sc = sf ? ((m_sc < SAT) ? m_sc + 1 : SAT) : m_sc;
        n_fc = fd ? ((m_fc < SAT) ? m_fc + 1 : SAT) : m_fc;

        chk("stall_f", int'(stall_f), int'(sf));
        chk("stall_d", int'(stall_d), int'(sd));
        chk("stall_e", int'(stall_e), int'(se));
        chk("flush_d", int'(flush_d), int'(fd));
        chk("flush_e", int'(flush_e), int'(fe));
        chk("flush_m", int'(flush_m), int'(fm));
        chk("md_abort", int'(md_abort), int'(ab));
        chk("md_timeout", int'(md_timeout), int'(m_to));
        chk("stall_count", int'(stall_count), m_sc);
        chk("flush_count", int'(flush_count), m_fc);
        chk("stall_flush_exclusive", int'((stall_d & flush_d) | (stall_e & flush_e)), 0);
    end

    always @(posedge clk) begin
        if (rst) begin
            m_md <= 0; m_cyc <= 0; m_to <= 0; m_sc <= 0; m_fc <= 0;
        end else begin
            m_md <= n_md; m_cyc <= n_cyc; m_to <= n_to; m_sc <= n_sc; m_fc <= n_fc;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; mem_read_e = 0; rd_e = 0; rs1_d = 0; rs2_d = 0;
        muldiv_start_e = 0; muldiv_done = 0;
    endtask

    task automatic set_lu();
        mem_read_e = 1; rd_e = 5'd5; rs1_d = 5'd3; rs2_d = 5'd5;
    endtask

    initial begin
        rst = 1;
        idle();
        step();
        step();
        rst = 0;
        repeat (5) step();
        chk("idle_stall_f", int'(stall_f), 0);
        chk("idle_stall_count", int'(stall_count), 0);
        chk("idle_flush_count", int'(flush_count), 0);

        // Load-use on rs2
        set_lu();
        #1;
        chk("lu_stall_f", int'(stall_f), 1);
        chk("lu_flush_e", int'(flush_e), 1);
        chk("lu_stall_e", int'(stall_e), 0);
        step();
        idle();
        chk("lu_stall_count", int'(stall_count), 1);

        // Load to x0 never hazards
        mem_read_e = 1;
        #1;
        chk("lu_x0_stall_f", int'(stall_f), 0);
        step();
        idle();
        chk("lu_x0_stall_count", int'(stall_count), 1);

        // Flush overrides load-use
        set_lu();
        flush = 1;
        #1;
        chk("fl_flush_d", int'(flush_d), 1);
        chk("fl_stall_f", int'(stall_f), 0);
        step();
        idle();
        chk("fl_flush_count", int'(flush_count), 1);
        chk("fl_stall_count", int'(stall_count), 1);

        // Mul/div with done four cycles after start
        muldiv_start_e = 1;
        #1;
        chk("md_start_stall", int'(stall_f), 1);
        step();
        muldiv_start_e = 0;
        for (int i = 0; i < 3; i++) begin
            chk("md_wait_stall", int'(stall_f), 1);
            step();
        end
        muldiv_done = 1;
        #1;
        chk("md_done_stall", int'(stall_f), 0);
        step();
        idle();
        chk("md_stall_count", int'(stall_count), 5);

        // Mul/div timeout: 8 stall cycles then a single abort
        muldiv_start_e = 1;
        step();
        muldiv_start_e = 0;
        for (int i = 0; i < MD_TIMEOUT - 1; i++) begin
            chk("to_wait_abort", int'(md_abort), 0);
            step();
        end
        chk("to_abort", int'(md_abort), 1);
        chk("to_abort_flush_e", int'(flush_e), 1);
        chk("to_abort_stall_f", int'(stall_f), 0);
        step();
        chk("to_abort_once", int'(md_abort), 0);
        chk("to_sticky", int'(md_timeout), 1);
        chk("to_stall_count", int'(stall_count), 13);
        step();
        step();
        chk("to_sticky_later", int'(md_timeout), 1);

        // Counter saturation
        set_lu();
        repeat (5) step();
        idle();
        chk("sat_stall_count", int'(stall_count), SAT);
        flush = 1;
        repeat (16) step();
        idle();
        chk("sat_flush_count", int'(flush_count), SAT);

        // Defensive flush while waiting on mul/div
        muldiv_start_e = 1;
        step();
        muldiv_start_e = 0;
        flush = 1;
        #1;
        chk("mdfl_abort", int'(md_abort), 1);
        chk("mdfl_flush_d", int'(flush_d), 1);
        chk("mdfl_stall_f", int'(stall_f), 0);
        step();
        idle();

        // Reset during MD_WAIT
        muldiv_start_e = 1;
        step();
        muldiv_start_e = 0;
        step();
        rst = 1;
        #1;
        chk("rst_md_abort", int'(md_abort), 0);
        step();
        rst = 0;
        #1;
        chk("rst_run_stall", int'(stall_f), 0);
        chk("rst_stall_count", int'(stall_count), 0);
        chk("rst_flush_count", int'(flush_count), 0);
        chk("rst_md_timeout", int'(md_timeout), 0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
